// File: rtl/buck_pwm_ctrl.sv
// ============================================================================
// Module   : buck_pwm_ctrl
// Brief    : Closed-loop integral PWM controller with soft-start and an
//            overcurrent fault latch with timed auto-restart.
// Revision : 1.0
// ============================================================================
`default_nettype none

module buck_pwm_ctrl #(
    parameter int WIDTH         = 18,
    parameter int PERIOD        = 200,
    parameter int CNT_W         = 8,
    parameter int DMAX          = 180,
    parameter int SS_STEP       = 2,
    parameter int KI_SHIFT      = 4,
    parameter int I_LIM         = 4096,
    parameter int FAULT_PERIODS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] v_ref,
    input  logic signed [WIDTH-1:0] v_out,
    input  logic signed [WIDTH-1:0] i_mag,
    output logic                    gate,
    output logic [CNT_W-1:0]        duty,
    output logic [1:0]              state,
    output logic                    fault,
    output logic                    period_strobe
);

    localparam int FC_W = (FAULT_PERIODS > 1) ? $clog2(FAULT_PERIODS) : 1;
    localparam logic signed [WIDTH-1:0] C_I_LIM = WIDTH'(I_LIM);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SS    = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_dlim;
    logic [CNT_W-1:0]  r_duty;
    logic [FC_W-1:0]   r_fcnt;
    logic              r_gate;

    logic              w_boundary;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_oc;
    logic signed [WIDTH:0] w_err;
    logic signed [WIDTH:0] w_err_sh;
    logic [WIDTH+1:0]  w_sum;
    logic [CNT_W-1:0]  w_acc_upd;
    logic [CNT_W:0]    w_dlim_inc;
    logic [CNT_W-1:0]  w_dlim_step;
    logic [CNT_W-1:0]  w_duty_upd;

    assign w_boundary = (r_cnt == CNT_W'(PERIOD - 1));
    assign w_cnt_next = w_boundary ? '0 : r_cnt + 1'b1;
    assign w_oc       = (i_mag > C_I_LIM);

    // One extra bit keeps the error exact for any pair of setpoint/measurement.
    assign w_err    = {v_ref[WIDTH-1], v_ref} - {v_out[WIDTH-1], v_out};
    assign w_err_sh = w_err >>> KI_SHIFT;
    assign w_sum    = {{(WIDTH + 2 - CNT_W){1'b0}}, r_acc} + {w_err_sh[WIDTH], w_err_sh};

    // Anti-windup: the integrator never leaves [0, dlim].
    always_comb begin
        if (w_sum[WIDTH+1]) begin
            w_acc_upd = '0;
        end else if (w_sum > {{(WIDTH + 2 - CNT_W){1'b0}}, r_dlim}) begin
            w_acc_upd = r_dlim;
        end else begin
            w_acc_upd = w_sum[CNT_W-1:0];
        end
    end

    assign w_dlim_inc  = {1'b0, r_dlim} + (CNT_W + 1)'(SS_STEP);
    assign w_dlim_step = (w_dlim_inc > (CNT_W + 1)'(DMAX)) ? CNT_W'(DMAX) : w_dlim_inc[CNT_W-1:0];
    assign w_duty_upd  = (w_acc_upd < w_dlim_step) ? w_acc_upd : w_dlim_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_dlim  <= '0;
            r_duty  <= '0;
            r_fcnt  <= '0;
            r_gate  <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_gate <= 1'b0;
            if (!en) begin
                r_state <= ST_IDLE;
                r_acc   <= '0;
                r_dlim  <= '0;
                r_duty  <= '0;
                r_fcnt  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_boundary) begin
                            r_state <= ST_SS;
                        end
                    end
                    ST_SS, ST_RUN: begin
                        if (w_oc) begin
                            r_state <= ST_FAULT;
                            r_acc   <= '0;
                            r_dlim  <= '0;
                            r_duty  <= '0;
                            r_fcnt  <= '0;
                        end else if (w_boundary) begin
                            r_acc  <= w_acc_upd;
                            r_dlim <= w_dlim_step;
                            r_duty <= w_duty_upd;
                            r_gate <= (w_cnt_next < w_duty_upd);
                            if (w_dlim_step == CNT_W'(DMAX)) begin
                                r_state <= ST_RUN;
                            end
                        end else begin
                            r_gate <= (w_cnt_next < r_duty);
                        end
                    end
                    default: begin
                        // Fault count saturates so a persistent overcurrent keeps us here.
                        if (w_boundary) begin
                            if (r_fcnt == FC_W'(FAULT_PERIODS - 1)) begin
                                if (!w_oc) begin
                                    r_state <= ST_SS;
                                end
                            end else begin
                                r_fcnt <= r_fcnt + 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign gate          = r_gate;
    assign duty          = r_duty;
    assign state         = r_state;
    assign fault         = (r_state == ST_FAULT);
    assign period_strobe = w_boundary;

endmodule

`default_nettype wire
